// File: rtl/mem_handshake_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_handshake_ctrl_pkg
//   Shared definitions for the CPU-facing memory responder.
//   - WORD_SIZE : data/address width shared with the CPU.
//   - state_t   : responder FSM encoding.
//   - op_t      : kind of request latched when a request is accepted.
// -----------------------------------------------------------------------------
package mem_handshake_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_handshake_ctrl_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
//   2^ADDR_W x WIDTH word storage with one synchronous write port and one
//   combinational read port.
//   Ports:
//     clk   : write clock
//     we    : write enable, commits wdata to mem[waddr] on posedge
//     waddr : write address
//     wdata : write data
//     raddr : read address
//     rdata : mem[raddr], combinational
// -----------------------------------------------------------------------------
module mem_array #(
  parameter int WIDTH  = mem_handshake_ctrl_pkg::WORD_SIZE,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: storage carries no reset so it maps onto plain RAM; contents survive
  // a controller reset. Non-blocking assignment keeps the write ordered after
  // every same-edge read of the array.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// mem_handshake_ctrl
//   Memory-side responder for the single-cycle CPU's readM/writeM handshake.
//   Accepts one request at a time, waits LATENCY edges, then pulses
//   inputReady (read, data driven) or ackOutput (write, committed on the edge
//   leaving the response cycle). Serves as unified I/D memory in the CPU bench.
//   Ports:
//     clk        : system clock
//     reset_n    : asynchronous active-low reset
//     readM      : read request level
//     writeM     : write request level (readM wins when both are high)
//     address    : word address, low DEPTH_LOG2 bits used (wraps)
//     data       : shared bus; driven only while answering a read, else Z
//     inputReady : one-cycle pulse, read data valid on data
//     ackOutput  : one-cycle pulse, write committed
// -----------------------------------------------------------------------------
module mem_handshake_ctrl #(
  parameter int WORD_SIZE  = mem_handshake_ctrl_pkg::WORD_SIZE,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2    // 1..15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput
);

  import mem_handshake_ctrl_pkg::*;

  // BUSY covers LATENCY-1 edges: the counter starts at LATENCY-2 and the
  // edge that sees zero moves to RESP.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  op_t                     op_q;
  logic                    hold_drive_q;  // keeps read data on the bus in HOLD
  logic                    mem_we;
  logic [WORD_SIZE-1:0]    rdata;
  logic                    drive_en;
  logic                    accept;
  logic                    unused_addr_hi;

  assign accept         = (state_q == IDLE) && (readM || writeM);
  assign unused_addr_hi = ^address[WORD_SIZE-1:DEPTH_LOG2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= OP_READ;
      hold_drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= address[DEPTH_LOG2-1:0];
        wdata_q <= data;
        op_q    <= readM ? OP_READ : OP_WRITE;
      end
      // Set while leaving a read response; dropped once readM is seen low.
      if (state_q == RESP && op_q == OP_READ)
        hold_drive_q <= 1'b1;
      else if (state_q == HOLD && !readM)
        hold_drive_q <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (readM || writeM) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        state_d = HOLD;
        if (op_q == OP_READ) begin
          inputReady = 1'b1;
        end else begin
          ackOutput = 1'b1;
          mem_we    = 1'b1;
        end
      end
      HOLD: begin
        if (!readM && !writeM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign drive_en = ((state_q == RESP) && (op_q == OP_READ)) || hold_drive_q;
  assign data     = drive_en ? rdata : 'z;

  mem_array #(
    .WIDTH (WORD_SIZE),
    .ADDR_W(DEPTH_LOG2)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(addr_q),
    .rdata(rdata)
  );

endmodule
